// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage; optional -j twiddle on stored differences when R2SDF_TRIVIAL_TWIDDLE_EN is defined.
// Latency: one clock from the accepting in_valid cycle to out_valid.
// No backpressure: in_valid low freezes all state (full stall).
module r2sdf_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] re_in,
    input  logic signed [WIDTH-1:0] im_in,
    output logic                    out_valid,
    output logic signed [WIDTH:0]   re_out,
    output logic signed [WIDTH:0]   im_out
);

    localparam int CW = $clog2(2 * DEPTH);

    logic [CW-1:0]         cnt;
    logic                  primed;
    logic                  phase;
    logic signed [WIDTH:0] dl_re [DEPTH];
    logic signed [WIDTH:0] dl_im [DEPTH];
    logic signed [WIDTH:0] head_re, head_im;
    logic signed [WIDTH:0] in_re_x, in_im_x;
    logic signed [WIDTH:0] sum_re, sum_im;
    logic signed [WIDTH:0] diff_re, diff_im;
    logic signed [WIDTH:0] wr_re, wr_im;
    logic signed [WIDTH:0] nxt_re, nxt_im;

    assign phase   = cnt[CW-1];
    assign head_re = dl_re[DEPTH-1];
    assign head_im = dl_im[DEPTH-1];

    always_comb begin
        in_re_x = {re_in[WIDTH-1], re_in};
        in_im_x = {im_in[WIDTH-1], im_in};
        sum_re  = head_re + in_re_x;
        sum_im  = head_im + in_im_x;
        diff_re = head_re - in_re_x;
        diff_im = head_im - in_im_x;
        wr_re   = in_re_x;
        wr_im   = in_im_x;
        nxt_re  = head_re;
        nxt_im  = head_im;
        if (phase) begin
`ifdef R2SDF_TRIVIAL_TWIDDLE_EN
            // (a + jb) * -j = b - ja
            wr_re = diff_im;
            wr_im = -diff_re;
`else
            wr_re = diff_re;
            wr_im = diff_im;
`endif
            nxt_re = sum_re;
            nxt_im = sum_im;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            re_out    <= '0;
            im_out    <= '0;
        end else begin
            out_valid <= in_valid & primed;
            if (in_valid) begin
                // 2*DEPTH is a power of two, so natural wrap gives the modulo
                cnt    <= cnt + CW'(1);
                re_out <= nxt_re;
                im_out <= nxt_im;
                if (cnt == CW'(DEPTH - 1))
                    primed <= 1'b1;
            end
        end
    end

    // Contents are left unreset; primed masks stale entries.
    always_ff @(posedge clock) begin
        if (in_valid && !reset) begin
            dl_re[0] <= wr_re;
            dl_im[0] <= wr_im;
            for (int i = 1; i < DEPTH; i++) begin
                dl_re[i] <= dl_re[i-1];
                dl_im[i] <= dl_im[i-1];
            end
        end
    end

endmodule

// File: tb/tb_r2sdf_stage.sv
// Directed bench: DEPTH=2 instance for stream, stall and reset cases; DEPTH=1 instance for extremes.
module tb_r2sdf_stage;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic              iv2 = 1'b0, iv1 = 1'b0;
    logic signed [7:0] re2 = '0, im2 = '0, re1 = '0, im1 = '0;
    logic              ov2, ov1;
    logic signed [8:0] ro2, io2, ro1, io1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    r2sdf_stage #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clock(clock), .reset(reset), .in_valid(iv2), .re_in(re2), .im_in(im2),
        .out_valid(ov2), .re_out(ro2), .im_out(io2)
    );

    r2sdf_stage #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(iv1), .re_in(re1), .im_in(im1),
        .out_valid(ov1), .re_out(ro1), .im_out(io1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send2(input int v, input logic vld);
        iv2 = vld;
        re2 = 8'(v);
        im2 = '0;
        tick();
    endtask

    task automatic send1(input int v);
        iv1 = 1'b1;
        re1 = 8'(v);
        im1 = '0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        iv2 = 1'b0;
        iv1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference for stream 1..8 on DEPTH=2; index k is input k+1
    int exp_vld [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
`ifdef R2SDF_TRIVIAL_TWIDDLE_EN
    int exp_re  [8] = '{0, 0, 4, 6, 0, 0, 12, 14};
    int exp_im  [8] = '{0, 0, 0, 0, 2, 2, 0, 0};
`else
    int exp_re  [8] = '{0, 0, 4, 6, -2, -2, 12, 14};
    int exp_im  [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

    initial begin
        // Reset state
        do_reset();
        chk("rst_ov2", int'(ov2), 0);
        chk("rst_re2", int'(ro2), 0);
        chk("rst_im2", int'(io2), 0);
        chk("rst_ov1", int'(ov1), 0);

        // Continuous stream 1..8
        for (int k = 0; k < 8; k++) begin
            send2(k + 1, 1'b1);
            chk($sformatf("str_vld%0d", k + 1), int'(ov2), exp_vld[k]);
            if (exp_vld[k] == 1) begin
                chk($sformatf("str_re%0d", k + 1), int'(ro2), exp_re[k]);
                chk($sformatf("str_im%0d", k + 1), int'(io2), exp_im[k]);
            end
        end
        send2(0, 1'b0);
        chk("idle_vld", int'(ov2), 0);

        // Same stream with a 3-cycle stall after input 3
        do_reset();
        for (int k = 0; k < 8; k++) begin
            send2(k + 1, 1'b1);
            chk($sformatf("gap_vld%0d", k + 1), int'(ov2), exp_vld[k]);
            if (exp_vld[k] == 1) begin
                chk($sformatf("gap_re%0d", k + 1), int'(ro2), exp_re[k]);
                chk($sformatf("gap_im%0d", k + 1), int'(io2), exp_im[k]);
            end
            if (k == 2) begin
                for (int g = 0; g < 3; g++) begin
                    send2(99, 1'b0);
                    chk($sformatf("gap_stall_vld%0d", g), int'(ov2), 0);
                    chk($sformatf("gap_stall_re%0d", g), int'(ro2), 4);
                end
            end
        end

        // Reset together with in_valid during phase 1
        do_reset();
        send2(1, 1'b1);
        send2(2, 1'b1);
        send2(3, 1'b1);
        chk("rv_pre_re", int'(ro2), 4);
        reset = 1'b1;
        send2(4, 1'b1);
        chk("rv_ov", int'(ov2), 0);
        chk("rv_re", int'(ro2), 0);
        reset = 1'b0;
        send2(10, 1'b1);
        chk("rv_post1_vld", int'(ov2), 0);
        send2(20, 1'b1);
        chk("rv_post2_vld", int'(ov2), 0);
        send2(30, 1'b1);
        chk("rv_post3_vld", int'(ov2), 1);
        chk("rv_post3_re", int'(ro2), 40);
        send2(0, 1'b0);

        // Extremes on DEPTH=1
        do_reset();
        send1(-128);
        chk("ext_vld0", int'(ov1), 0);
        send1(127);
        chk("ext_sum_vld", int'(ov1), 1);
        chk("ext_sum_re", int'(ro1), -1);
        chk("ext_sum_im", int'(io1), 0);
        send1(0);
        chk("ext_diff_vld", int'(ov1), 1);
`ifdef R2SDF_TRIVIAL_TWIDDLE_EN
        chk("ext_diff_re", int'(ro1), 0);
        chk("ext_diff_im", int'(io1), 255);
`else
        chk("ext_diff_re", int'(ro1), -255);
        chk("ext_diff_im", int'(io1), 0);
`endif
        iv1 = 1'b0;
        tick();
        chk("ext_idle_vld", int'(ov1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/r2sdf_stage.md
R2SDF_STAGE -- requirements
Module: r2sdf_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the signed input sample width per real/imag component.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the feedback delay length in samples (power of two, >= 1).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  sample on re_in/im_in accepted this cycle.
REQ-006 SHALL have ports re_in, im_in  input  WIDTH  signed two's-complement input sample.
REQ-007 SHALL have port out_valid  output  1  re_out/im_out hold a valid sample.
REQ-008 SHALL have ports re_out, im_out  output  WIDTH+1  signed, registered stage output.

Function
REQ-009 SHALL implement a radix-2 single-path delay-feedback stage: a DEPTH-entry complex delay line of WIDTH+1 bits per component, a complex add/subtract butterfly, and an output multiplexer.
REQ-010 SHALL keep a sample counter, modulo 2*DEPTH, advancing only on in_valid; its MSB is phase (0 = fill, 1 = butterfly).
REQ-011 SHALL, on in_valid in phase 0: write the sign-extended input into the delay line; drive the output register with the delay-line head (difference from the previous block).
REQ-012 SHALL, on in_valid in phase 1: drive the output register with head + input; write head - input into the delay line.
REQ-013 SHALL shift the delay line only on in_valid; with in_valid low, no state changes (full stall) and out_valid is 0 the next cycle.
REQ-014 SHALL produce the output exactly 1 clock after the accepting in_valid cycle.
REQ-015 SHALL keep a primed flag, set once DEPTH samples have been accepted since reset; out_valid = registered (in_valid AND primed-at-acceptance).
REQ-016 SHALL compute in WIDTH+1 bits with sign extension and no saturation or rounding; no overflow is possible at that width.
REQ-017 SHALL wrap the counter from 2*DEPTH-1 to 0 with no bubble; the first DEPTH inputs after reset produce no valid output.

Reset
REQ-018 SHALL, on reset high at a clock edge, clear counter, primed, out_valid, re_out and im_out to 0.
REQ-019 SHALL leave delay-line contents unspecified after reset; the primed flag masks them.
REQ-020 SHALL give reset priority over a simultaneous in_valid, so that sample is discarded; reset mid-block restarts at phase 0.

Configuration
REQ-021 SHALL, with macro R2SDF_TRIVIAL_TWIDDLE_EN defined, multiply the phase-1 difference by -j before storing: stored re = diff im, stored im = -(diff re).
REQ-022 SHALL, without R2SDF_TRIVIAL_TWIDDLE_EN, store the difference unmodified; the sums path is identical in both builds.

Verification
REQ-023 SHALL cover: WIDTH=8, DEPTH=2, real inputs 1,2,3,4 with continuous in_valid -> out_valid 0 for the first 2 samples; then outputs 4, 6 (im 0).
REQ-024 SHALL cover: the same stream continued with 5,6 (macro off) -> outputs -2, -2 (im 0), then sums resume with inputs 7,8.
REQ-025 SHALL cover: the same stream with R2SDF_TRIVIAL_TWIDDLE_EN defined -> outputs during inputs 5,6 are re 0, im +2, each.
REQ-026 SHALL cover: extremes, inputs -128 then 127 (DEPTH=1) -> sum output -1; stored difference -255, emitted without wrap.
REQ-027 SHALL cover: in_valid deasserted 3 cycles mid-block -> counter, delay line and outputs frozen, out_valid 0; resumed outputs match the no-gap reference.
REQ-028 SHALL cover: reset asserted together with in_valid during phase 1 -> that sample is dropped, out_valid 0, and the next 2 accepted samples produce no output.
